// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N-input multiplexer.
package mux_pkg;

    // Source-selection modes
    localparam int MODO_SELECAO = 0;  // explicit select through Sinal
    localparam int MODO_RODIZIO = 1;  // round-robin over Pedido

    // Width of a source index: never narrower than one bit
    function automatic int largura_sel(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            return 1;
        end else begin
            return r;
        end
    endfunction

endpackage : mux_pkg

// File: rtl/mux_reg_arb_arbitro_rr.sv
// Round-robin arbiter: picks the first requesting source at or after the
// pointer, wrapping modulo N. Purely combinational.
module arbitro_rr #(
    parameter int N  = 3,
    parameter int SW = 2
) (
    input  logic [N-1:0]  pedido_i,
    input  logic [SW-1:0] ponteiro_i,
    output logic [SW-1:0] concessao_o,
    output logic          tem_pedido_o
);

    // (pointer + k) mod N, assuming the pointer itself is below N
    function automatic logic [SW-1:0] indice(input logic [SW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            return SW'(s - N);
        end else begin
            return SW'(s);
        end
    endfunction

    // Scan downward so the request closest after the pointer is assigned last and wins
    always_comb begin
        concessao_o  = '0;
        tem_pedido_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pedido_i[indice(ponteiro_i, k)]) begin
                concessao_o  = indice(ponteiro_i, k);
                tem_pedido_o = 1'b1;
            end else begin
                concessao_o  = concessao_o;
                tem_pedido_o = tem_pedido_o;
            end
        end
    end

endmodule : arbitro_rr

// File: rtl/mux_reg_arb.sv
// Registered N-input multiplexer with valid/ready handshake. The source is
// chosen either by an explicit select or by a round-robin arbiter; the
// chosen word is loaded into an output register that can be back-pressured.
module mux_reg_arb
    import mux_pkg::*;
#(
    parameter  int LARGURA    = 3,
    parameter  int N_ENTRADAS = 3,
    parameter  int MODO       = MODO_SELECAO,
    localparam int SW         = largura_sel(N_ENTRADAS)
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic [N_ENTRADAS*LARGURA-1:0] Dados,
    input  logic [N_ENTRADAS-1:0]         Pedido,
    input  logic [SW-1:0]                 Sinal,
    output logic [N_ENTRADAS-1:0]         Aceito,
    output logic [LARGURA-1:0]            Saida,
    output logic                          SaidaValida,
    output logic [SW-1:0]                 OrigemSaida,
    input  logic                          Pronto
);

    logic [SW-1:0]      cand_s;
    logic               tem_cand_s;
    logic               pedido_sel_s;
    logic [LARGURA-1:0] dado_sel_s;
    logic               carrega_s;
    logic               transf_s;

    logic [LARGURA-1:0] saida_q, saida_d;
    logic               valida_q, valida_d;
    logic [SW-1:0]      origem_q, origem_d;

    if (MODO == MODO_RODIZIO) begin : g_rodizio
        logic [SW-1:0] ponteiro_q, ponteiro_d;
        logic [SW-1:0] concessao_s;
        logic          tem_pedido_s;
        logic          sinal_unused_s;

        assign sinal_unused_s = ^Sinal;

        arbitro_rr #(
            .N  (N_ENTRADAS),
            .SW (SW)
        ) u_arbitro (
            .pedido_i     (Pedido),
            .ponteiro_i   (ponteiro_q),
            .concessao_o  (concessao_s),
            .tem_pedido_o (tem_pedido_s)
        );

        assign cand_s     = concessao_s;
        assign tem_cand_s = tem_pedido_s;

        // Pointer moves just past the granted source, only when a word is taken
        always_comb begin
            ponteiro_d = ponteiro_q;
            if (transf_s) begin
                if (int'(cand_s) == N_ENTRADAS - 1) begin
                    ponteiro_d = '0;
                end else begin
                    ponteiro_d = cand_s + SW'(1);
                end
            end else begin
                ponteiro_d = ponteiro_q;
            end
        end

        // Round-robin pointer register
        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                ponteiro_q <= '0;
            end else begin
                ponteiro_q <= ponteiro_d;
            end
        end
    end else begin : g_selecao
        // An out-of-range select simply yields no candidate
        assign cand_s     = Sinal;
        assign tem_cand_s = (int'(Sinal) < N_ENTRADAS);
    end

    // Fetch the candidate's request bit and data word without out-of-range indexing
    always_comb begin
        pedido_sel_s = 1'b0;
        dado_sel_s   = '0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (int'(cand_s) == i) begin
                pedido_sel_s = Pedido[i];
                dado_sel_s   = Dados[i*LARGURA +: LARGURA];
            end else begin
                pedido_sel_s = pedido_sel_s;
                dado_sel_s   = dado_sel_s;
            end
        end
    end

    // Output register can take a word when empty or being drained this cycle
    assign carrega_s = !valida_q || Pronto;

    // Transfer qualifier; gated by reset so no ready is shown while in reset
    assign transf_s = Resetn && tem_cand_s && pedido_sel_s && carrega_s;

    // One-hot ready toward the granted source, zero otherwise
    always_comb begin
        Aceito = '0;
        for (int i = 0; i < N_ENTRADAS; i++) begin
            if (transf_s && (int'(cand_s) == i)) begin
                Aceito[i] = 1'b1;
            end else begin
                Aceito[i] = 1'b0;
            end
        end
    end

    // Output register next state: load on transfer, drop valid on a bare consume
    always_comb begin
        saida_d  = saida_q;
        valida_d = valida_q;
        origem_d = origem_q;
        if (transf_s) begin
            saida_d  = dado_sel_s;
            valida_d = 1'b1;
            origem_d = cand_s;
        end else if (Pronto) begin
            valida_d = 1'b0;
        end else begin
            valida_d = valida_q;
        end
    end

    // Output word, valid flag and origin registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            saida_q  <= '0;
            valida_q <= 1'b0;
            origem_q <= '0;
        end else begin
            saida_q  <= saida_d;
            valida_q <= valida_d;
            origem_q <= origem_d;
        end
    end

    assign Saida       = saida_q;
    assign SaidaValida = valida_q;
    assign OrigemSaida = origem_q;

endmodule : mux_reg_arb

// File: tb/tb_mux_reg_arb.sv
// Bench for mux_reg_arb: three configurations (3x3 select, 4x4 round-robin,
// 8x8 select) driven one cycle at a time against a small reference model.
module tb_mux_reg_arb;

    logic Clock;
    logic Resetn;

    logic [8:0]  dados_a;
    logic [2:0]  ped_a, ac_a, saida_a;
    logic [1:0]  sel_a, orig_a;
    logic        val_a, pr_a;

    logic [15:0] dados_b;
    logic [3:0]  ped_b, ac_b, saida_b;
    logic [1:0]  sel_b, orig_b;
    logic        val_b, pr_b;

    logic [63:0] dados_c;
    logic [7:0]  ped_c, ac_c, saida_c;
    logic [2:0]  sel_c, orig_c;
    logic        val_c, pr_c;

    typedef struct {
        int orig;
        int dado;
    } esp_t;

    esp_t fila[$];
    int   m_val[3];
    int   m_sai[3];
    int   m_ori[3];
    int   m_ptr[3];
    int   checks;
    int   errors;

    mux_reg_arb #(.LARGURA(3), .N_ENTRADAS(3), .MODO(0)) u_dut_a (
        .Clock(Clock), .Resetn(Resetn), .Dados(dados_a), .Pedido(ped_a), .Sinal(sel_a),
        .Aceito(ac_a), .Saida(saida_a), .SaidaValida(val_a), .OrigemSaida(orig_a), .Pronto(pr_a)
    );

    mux_reg_arb #(.LARGURA(4), .N_ENTRADAS(4), .MODO(1)) u_dut_b (
        .Clock(Clock), .Resetn(Resetn), .Dados(dados_b), .Pedido(ped_b), .Sinal(sel_b),
        .Aceito(ac_b), .Saida(saida_b), .SaidaValida(val_b), .OrigemSaida(orig_b), .Pronto(pr_b)
    );

    mux_reg_arb #(.LARGURA(8), .N_ENTRADAS(8), .MODO(0)) u_dut_c (
        .Clock(Clock), .Resetn(Resetn), .Dados(dados_c), .Pedido(ped_c), .Sinal(sel_c),
        .Aceito(ac_c), .Saida(saida_c), .SaidaValida(val_c), .OrigemSaida(orig_c), .Pronto(pr_c)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    function automatic int dado_de(input int d, input int g);
        case (d)
            0:       return int'(dados_a[g*3 +: 3]);
            1:       return int'(dados_b[g*4 +: 4]);
            default: return int'(dados_c[g*8 +: 8]);
        endcase
    endfunction

    task automatic le_saidas(input int d, output logic [31:0] ac, output logic [31:0] sai,
                             output logic [31:0] ori, output logic [31:0] val);
        case (d)
            0:       begin ac = 32'(ac_a); sai = 32'(saida_a); ori = 32'(orig_a); val = 32'(val_a); end
            1:       begin ac = 32'(ac_b); sai = 32'(saida_b); ori = 32'(orig_b); val = 32'(val_b); end
            default: begin ac = 32'(ac_c); sai = 32'(saida_c); ori = 32'(orig_c); val = 32'(val_c); end
        endcase
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0;
            m_sai[i] = 0;
            m_ori[i] = 0;
            m_ptr[i] = 0;
        end
        fila.delete();
    endtask

    // One cycle on DUT d; called just after a falling edge
    task automatic passo(input int d, input logic [7:0] ped, input int sel, input logic pr,
                         input string tag);
        int n;
        int g;
        bit tem;
        bit tr;
        logic [31:0] ac_o, sai_o, ori_o, val_o;
        esp_t e;
        case (d)
            0:       begin ped_a = ped[2:0]; sel_a = 2'(sel); pr_a = pr; n = 3; end
            1:       begin ped_b = ped[3:0]; sel_b = 2'(sel); pr_b = pr; n = 4; end
            default: begin ped_c = ped;      sel_c = 3'(sel); pr_c = pr; n = 8; end
        endcase
        #1;
        tem = 1'b0;
        g   = 0;
        if (d == 1) begin
            for (int k = 0; k < n; k++) begin
                if (!tem && ped[(m_ptr[d] + k) % n]) begin
                    tem = 1'b1;
                    g   = (m_ptr[d] + k) % n;
                end
            end
        end else if (sel < n) begin
            tem = 1'b1;
            g   = sel;
        end
        tr = tem && ped[g] && ((m_val[d] == 0) || pr);
        le_saidas(d, ac_o, sai_o, ori_o, val_o);
        verifica({tag, ":aceito"}, ac_o, tr ? (32'd1 << g) : 32'd0);
        if (tr) begin
            fila.push_back('{orig: g, dado: dado_de(d, g)});
            m_val[d] = 1;
            m_sai[d] = dado_de(d, g);
            m_ori[d] = g;
            m_ptr[d] = (g + 1) % n;
        end else if (pr) begin
            m_val[d] = 0;
        end
        @(posedge Clock);
        @(negedge Clock);
        le_saidas(d, ac_o, sai_o, ori_o, val_o);
        if (tr) begin
            e = fila.pop_front();
            verifica({tag, ":saida"}, sai_o, e.dado);
            verifica({tag, ":origem"}, ori_o, e.orig);
        end else begin
            verifica({tag, ":saida_retida"}, sai_o, m_sai[d]);
            verifica({tag, ":origem_retida"}, ori_o, m_ori[d]);
        end
        verifica({tag, ":valida"}, val_o, m_val[d]);
    endtask

    initial begin
        logic [31:0] ac_o, sai_o, ori_o, val_o;
        checks  = 0;
        errors  = 0;
        Resetn  = 1'b0;
        dados_a = {3'd7, 3'd2, 3'd5};
        dados_b = {4'hD, 4'hC, 4'hB, 4'hA};
        for (int i = 0; i < 8; i++) dados_c[i*8 +: 8] = 8'hA0 + 8'(i);
        ped_a = 3'b010; sel_a = 2'd1; pr_a = 1'b1;
        ped_b = 4'b0000; sel_b = 2'd0; pr_b = 1'b1;
        ped_c = 8'h00;  sel_c = 3'd0; pr_c = 1'b1;
        modelo_reset();

        // Reset state, with a request that would otherwise be granted
        repeat (2) @(negedge Clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            le_saidas(d, ac_o, sai_o, ori_o, val_o);
            verifica("reset:aceito", ac_o, 32'd0);
            verifica("reset:saida", sai_o, 32'd0);
            verifica("reset:valida", val_o, 32'd0);
            verifica("reset:origem", ori_o, 32'd0);
        end
        Resetn = 1'b1;

        // Explicit select
        passo(0, 8'b010, 1, 1'b1, "sel1");
        passo(0, 8'b111, 3, 1'b1, "sel_fora");
        passo(0, 8'b011, 2, 1'b1, "sel_sem_pedido");
        passo(0, 8'b001, 0, 1'b1, "carrega0");
        dados_a[2:0] = 3'd3;
        for (int i = 0; i < 5; i++) passo(0, 8'b001, 0, 1'b0, "stall");
        passo(0, 8'b001, 0, 1'b1, "libera");
        passo(0, 8'b100, 2, 1'b1, "carrega2");
        passo(0, 8'b100, 2, 1'b0, "stall2");

        // Asynchronous reset in the middle of a stall
        pr_a = 1'b1;
        #2;
        Resetn = 1'b0;
        #1;
        le_saidas(0, ac_o, sai_o, ori_o, val_o);
        verifica("rst_stall:aceito", ac_o, 32'd0);
        verifica("rst_stall:saida", sai_o, 32'd0);
        verifica("rst_stall:valida", val_o, 32'd0);
        verifica("rst_stall:origem", ori_o, 32'd0);
        modelo_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        passo(0, 8'b100, 2, 1'b1, "pos_reset");
        passo(0, 8'b000, 0, 1'b1, "esvazia_a");

        // Round-robin, all requesting: 0,1,2,3,0
        for (int i = 0; i < 5; i++) passo(1, 8'b1111, 0, 1'b1, "rr_todos");
        @(negedge Clock);
        Resetn = 1'b0;
        modelo_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        passo(1, 8'b1111, 0, 1'b1, "rr_ptr_reset");
        passo(1, 8'b1010, 0, 1'b1, "rr_alt");
        passo(1, 8'b1010, 0, 1'b1, "rr_alt");
        passo(1, 8'b1010, 0, 1'b0, "rr_stall");
        passo(1, 8'b1010, 0, 1'b1, "rr_alt");
        passo(1, 8'b1010, 0, 1'b1, "rr_alt");
        passo(1, 8'b0000, 0, 1'b1, "esvazia_b");

        // Wide sweep, one word per cycle with no bubbles
        for (int i = 0; i < 8; i++) passo(2, 8'hFF, i, 1'b1, "varredura");
        passo(2, 8'h00, 0, 1'b1, "esvazia_c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_reg_arb
